// File: rtl/vwrite_burst_if.sv
// Databus write port plus local two-port memory port of vwrite_burst.
// master = the write unit; slave = interconnect / memory side.
interface vwrite_burst_if #(
  parameter int ADDR_W     = 12,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
);
  logic                    databus_ready_0;
  logic                    databus_valid_0;
  logic [AXI_ADDR_W-1:0]   databus_addr_0;
  logic [AXI_DATA_W-1:0]   databus_rdata_0;
  logic [AXI_DATA_W-1:0]   databus_wdata_0;
  logic [AXI_DATA_W/8-1:0] databus_wstrb_0;
  logic [LEN_W-1:0]        databus_len_0;
  logic                    databus_last_0;

  logic [ADDR_W-1:0]       ext_2p_addr_out_0;
  logic [ADDR_W-1:0]       ext_2p_addr_in_0;
  logic                    ext_2p_write_0;
  logic                    ext_2p_read_0;
  logic [AXI_DATA_W-1:0]   ext_2p_data_out_0;
  logic [AXI_DATA_W-1:0]   ext_2p_data_in_0;

  modport master (
    input  databus_ready_0, databus_rdata_0, databus_last_0, ext_2p_data_in_0,
    output databus_valid_0, databus_addr_0, databus_wdata_0, databus_wstrb_0,
           databus_len_0, ext_2p_addr_out_0, ext_2p_addr_in_0, ext_2p_write_0,
           ext_2p_read_0, ext_2p_data_out_0
  );

  modport slave (
    output databus_ready_0, databus_rdata_0, databus_last_0, ext_2p_data_in_0,
    input  databus_valid_0, databus_addr_0, databus_wdata_0, databus_wstrb_0,
           databus_len_0, ext_2p_addr_out_0, ext_2p_addr_in_0, ext_2p_write_0,
           ext_2p_read_0, ext_2p_data_out_0
  );
endinterface

// File: rtl/vwrite_burst.sv
// Captures in0 into one ping-pong half of a local buffer and bursts the other half out on the databus; VWRITE_REVERSE_EN adds bit-reversed capture addressing.
// First beat 3 cycles after run; a 2-entry prefetch FIFO holds data under backpressure and gives 1 beat/cycle while ready stays high.
module vwrite_burst #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int PERIOD_W   = 10,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  running,
  output logic                  done,
  vwrite_burst_if.master        bus,
  input  logic [DATA_W-1:0]     in0,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [PERIOD_W-1:0]   perA,
  input  logic [ADDR_W-1:0]     incrA,
  input  logic [LEN_W-1:0]      length,
  input  logic                  pingPong,
  input  logic [PERIOD_W-1:0]   perB,
  input  logic [ADDR_W-1:0]     startB,
  input  logic [ADDR_W-1:0]     incrB,
  input  logic [31:0]           delay0,
  input  logic                  disabled
`ifdef VWRITE_REVERSE_EN
  ,
  input  logic                  reverseB
`endif
);

  typedef enum logic [1:0] {B_IDLE, B_DLY, B_WR} b_state_t;

  logic start;
  logic pp_state, pp_next;
  logic [ADDR_W-1:0] start_b_inst, start_a;

  logic                done_a, done_b;
  logic [AXI_ADDR_W-1:0] base_addr;

  b_state_t            b_state;
  logic [31:0]         b_dly;
  logic [PERIOD_W-1:0] b_cnt;
  logic [ADDR_W-1:0]   b_addr;
  logic                b_wr;

  logic [ADDR_W-1:0]   a_raddr;
  logic [PERIOD_W-1:0] a_issued;
  logic                rd_pend;
  logic                rd_en;
  logic [AXI_DATA_W-1:0] fifo_mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          occ;
  logic [2:0]          fill_after_pop;
  logic                valid, pop, last_pop;

  wire unused_ok = &{1'b0, running, bus.databus_rdata_0};

  assign start   = run && !disabled;
  assign pp_next = pingPong ? !pp_state : 1'b0;
  assign start_b_inst = pingPong ? {pp_next, startB[ADDR_W-2:0]} : startB;
  assign start_a = {!pp_next, {(ADDR_W-1){1'b0}}};

  // Capture side: delay, then exactly perB back-to-back writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_state <= B_IDLE;
      done_b  <= 1'b1;
      b_dly   <= '0;
      b_cnt   <= '0;
      b_addr  <= '0;
      b_wr    <= 1'b0;
    end else if (start) begin
      done_b <= 1'b0;
      b_cnt  <= '0;
      b_addr <= start_b_inst;
      b_dly  <= delay0;
      if (perB != '0 && delay0 == 32'd0) begin
        b_wr    <= 1'b1;
        b_state <= B_WR;
      end else begin
        b_wr    <= 1'b0;
        b_state <= B_DLY;
      end
    end else begin
      case (b_state)
        B_DLY: begin
          if (perB == '0) begin
            done_b  <= 1'b1;
            b_state <= B_IDLE;
          end else if (b_dly <= 32'd1) begin
            b_wr    <= 1'b1;
            b_state <= B_WR;
          end else begin
            b_dly <= b_dly - 32'd1;
          end
        end
        B_WR: begin
          if (b_cnt == perB - 1'b1) begin
            b_wr    <= 1'b0;
            done_b  <= 1'b1;
            b_state <= B_IDLE;
          end else begin
            b_cnt  <= b_cnt + 1'b1;
            b_addr <= b_addr + incrB;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

`ifdef VWRITE_REVERSE_EN
  logic [ADDR_W-2:0] b_low_rev;
  always_comb begin
    b_low_rev = '0;
    for (int i = 0; i < ADDR_W-1; i++) b_low_rev[i] = b_addr[ADDR_W-2-i];
  end
  assign bus.ext_2p_addr_out_0 = reverseB ? {b_addr[ADDR_W-1], b_low_rev} : b_addr;
`else
  assign bus.ext_2p_addr_out_0 = b_addr;
`endif

  assign bus.ext_2p_write_0    = b_wr;
  assign bus.ext_2p_data_out_0 = in0;

  // A pop this cycle frees a slot, so the next read may issue without a bubble.
  assign valid          = (occ != 2'd0) && !done_a;
  assign pop            = valid && bus.databus_ready_0;
  assign last_pop       = pop && bus.databus_last_0;
  assign fill_after_pop = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
  assign rd_en          = !done_a && (a_issued < perA) && (fill_after_pop < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_a      <= 1'b1;
      base_addr   <= '0;
      pp_state    <= 1'b0;
      a_raddr     <= '0;
      a_issued    <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (start) begin
      done_a    <= 1'b0;
      base_addr <= ext_addr;
      pp_state  <= pp_next;
      a_raddr   <= start_a;
      a_issued  <= '0;
      rd_pend   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
    end else if (last_pop) begin
      // Burst complete: drop buffered words and any read still returning.
      done_a  <= 1'b1;
      rd_pend <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (!done_a && perA == '0) done_a <= 1'b1;
      rd_pend <= rd_en;
      if (rd_en) begin
        a_raddr  <= a_raddr + incrA;
        a_issued <= a_issued + 1'b1;
      end
      if (rd_pend) begin
        fifo_mem[wr_ptr] <= bus.ext_2p_data_in_0;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  assign bus.ext_2p_read_0    = rd_en;
  assign bus.ext_2p_addr_in_0 = a_raddr;
  assign bus.databus_valid_0  = valid;
  assign bus.databus_wdata_0  = fifo_mem[rd_ptr];
  assign bus.databus_addr_0   = base_addr;
  assign bus.databus_wstrb_0  = '1;
  assign bus.databus_len_0    = length;

  assign done = done_a & done_b;

endmodule

// File: tb/tb_vwrite_burst.sv
// Scoreboard bench for vwrite_burst: directed runs push expected beats/writes; a forked monitor pops and compares.
module tb_vwrite_burst;
  localparam int ADDR_W = 12;
  localparam int PERIOD_W = 10;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LEN_W = 8;

  typedef struct packed {logic [31:0] n; logic [DW-1:0] d;} beat_t;
  typedef struct packed {logic [31:0] n; logic [ADDR_W-1:0] a; logic [DW-1:0] d;} wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic running = 1'b0;
  logic done;
  logic [DW-1:0] in0;
  logic [AW-1:0] ext_addr = '0;
  logic [PERIOD_W-1:0] perA = '0;
  logic [ADDR_W-1:0] incrA = 12'd1;
  logic [LEN_W-1:0] length = '0;
  logic pingPong = 1'b0;
  logic [PERIOD_W-1:0] perB = '0;
  logic [ADDR_W-1:0] startB = '0;
  logic [ADDR_W-1:0] incrB = 12'd1;
  logic [31:0] delay0 = '0;
  logic disabled = 1'b0;
`ifdef VWRITE_REVERSE_EN
  logic reverseB = 1'b0;
`endif

  logic [DW-1:0] in_base = '0;
  int rdy_mode = 0;
  int last_at = 4;
  int cyc = 0, n_run = 0, wr_seen = 0, acc = 0, rd_total = 0;
  int checks = 0, errors = 0, max_out = 0;

  logic [DW-1:0] mem [0:4095];
  logic pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  beat_t exp_beats[$];
  wr_t   exp_wr[$];

  always #5 clk = ~clk;

  vwrite_burst_if #(.ADDR_W(ADDR_W), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LEN_W)) bus ();

  vwrite_burst #(.DATA_W(DW), .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W),
                 .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done), .bus(bus),
    .in0(in0), .ext_addr(ext_addr), .perA(perA), .incrA(incrA), .length(length),
    .pingPong(pingPong), .perB(perB), .startB(startB), .incrB(incrB),
    .delay0(delay0), .disabled(disabled)
`ifdef VWRITE_REVERSE_EN
    , .reverseB(reverseB)
`endif
  );

  assign bus.databus_rdata_0 = '0;
  assign bus.databus_ready_0 = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;
  assign bus.databus_last_0  = bus.databus_valid_0 && (acc == last_at - 1);
  assign in0 = in_base + 32'(wr_seen);

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.ext_2p_write_0) mem[bus.ext_2p_addr_out_0] <= bus.ext_2p_data_out_0;
    if (bus.ext_2p_read_0) bus.ext_2p_data_in_0 <= mem[bus.ext_2p_addr_in_0];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst || (run && !disabled)) begin
      n_run <= 1; wr_seen <= 0; acc <= 0; rd_total <= 0;
    end else begin
      n_run <= n_run + 1;
      if (bus.ext_2p_write_0) wr_seen <= wr_seen + 1;
      if (bus.databus_valid_0 && bus.databus_ready_0) acc <= acc + 1;
      if (bus.ext_2p_read_0) rd_total <= rd_total + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic stall_prev = 1'b0;
    logic [DW-1:0] stall_dat = '0;
    beat_t b;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        chk("hold_valid", bus.databus_valid_0, 1);
        chk("hold_wdata", bus.databus_wdata_0, stall_dat);
      end
      if (bus.databus_valid_0 && bus.databus_ready_0) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected none", bus.databus_wdata_0);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_data", bus.databus_wdata_0, b.d);
          if (b.n != 0) chk("beat_cycle", n_run, b.n);
        end
      end
      stall_prev = bus.databus_valid_0 && !bus.databus_ready_0 && !(run && !disabled);
      stall_dat  = bus.databus_wdata_0;
      if (bus.ext_2p_write_0) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%0h expected none", bus.ext_2p_addr_out_0);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", bus.ext_2p_addr_out_0, w.a);
          chk("wr_data", bus.ext_2p_data_out_0, w.d);
          chk("wr_cycle", n_run, w.n);
        end
      end
      if (!done && (rd_total - acc) > max_out) max_out = rd_total - acc;
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic wait_n(input int target);
    int guard = 0;
    do begin @(negedge clk); guard++; end while (n_run != target && guard < 200);
    if (n_run != target) begin
      checks++; errors++;
      $display("FAIL wait_cycle: got %0d expected %0d", n_run, target);
    end
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    do begin @(negedge clk); guard++; end while (!done && guard < 300);
    chk(name, done, 1);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] base, input logic [DW-1:0] d0);
    for (int i = 0; i < 4; i++) begin
      pl_en = 1'b1; pl_addr = base + ADDR_W'(i); pl_data = d0 + DW'(i);
      tick(1);
    end
    pl_en = 1'b0;
  endtask

  task automatic push_beats(input logic [DW-1:0] d0, input int n0);
    for (int i = 0; i < 4; i++) exp_beats.push_back({32'(n0 == 0 ? 0 : n0 + i), d0 + DW'(i)});
  endtask

  task automatic push_writes(input logic [ADDR_W-1:0] a0, input logic [DW-1:0] d0, input int n0);
    for (int i = 0; i < 4; i++) exp_wr.push_back({32'(n0 + i), a0 + ADDR_W'(i), d0 + DW'(i)});
  endtask

  initial begin
    fork monitor(); join_none

    // Reset state
    tick(3);
    chk("rst_done", done, 1);
    chk("rst_valid", bus.databus_valid_0, 0);
    chk("rst_write", bus.ext_2p_write_0, 0);
    chk("rst_read", bus.ext_2p_read_0, 0);
    chk("rst_addr", bus.databus_addr_0, 0);
    rst = 1'b1;
    tick(2);
    chk("post_rst_done", done, 1);

    // run while disabled does nothing
    disabled = 1'b1; perA = 4; perB = 4; delay0 = 1;
    start_run();
    tick(8);
    chk("disabled_done", done, 1);
    chk("disabled_valid", bus.databus_valid_0, 0);
    disabled = 1'b0;

    // Capture only
    perA = 0; perB = 4; startB = 12'h010; incrB = 1; delay0 = 2; pingPong = 0; in_base = 32'hA0;
    push_writes(12'h010, 32'hA0, 3);
    start_run();
    wait_n(6);
    chk("cap_done_early", done, 0);
    wait_n(7);
    chk("cap_done", done, 1);
    chk("cap_drained", exp_wr.size(), 0);

    // Transmit, ready held high
    preload(12'h800, 32'd1);
    perA = 4; perB = 0; length = 3; ext_addr = 32'h1000; incrA = 1; last_at = 4; max_out = 0;
    push_beats(32'd1, 3);
    start_run();
    wait_n(2);
    chk("tx_addr", bus.databus_addr_0, 32'h1000);
    chk("tx_len", bus.databus_len_0, 3);
    chk("tx_wstrb", bus.databus_wstrb_0, 4'hF);
    wait_n(6);
    chk("tx_done_early", done, 0);
    wait_n(7);
    chk("tx_done", done, 1);
    chk("tx_drained", exp_beats.size(), 0);

    // Backpressure
    rdy_mode = 1; max_out = 0;
    push_beats(32'd1, 0);
    start_run();
    wait_done("bp_done");
    chk("bp_drained", exp_beats.size(), 0);
    chk("bp_outstanding_le2", (max_out <= 2), 1);
    rdy_mode = 0;

    // Abort after two beats, restart from startA
    push_beats(32'd1, 3);
    start_run();
    tick(4);
    chk("abort_two_beats", acc, 2);
    rdy_mode = 2;
    exp_beats.delete();
    push_beats(32'd1, 3);
    run = 1'b1;
    tick(1);
    run = 1'b0; rdy_mode = 0;
    wait_n(1);
    chk("abort_flush", bus.databus_valid_0, 0);
    wait_done("abort_done");
    chk("abort_drained", exp_beats.size(), 0);

    // Ping-pong: run 1 captures bank 1 and sends bank 0, run 2 swaps
    preload(12'h000, 32'h11);
    perA = 4; perB = 4; startB = 12'h000; delay0 = 10; pingPong = 1; in_base = 32'hB0;
    push_beats(32'h11, 3);
    push_writes(12'h800, 32'hB0, 11);
    start_run();
    wait_n(8);
    chk("pp1_waitB", done, 0);
    wait_n(14);
    chk("pp1_done_early", done, 0);
    wait_n(15);
    chk("pp1_done", done, 1);
    in_base = 32'hC0;
    push_beats(32'hB0, 3);
    push_writes(12'h000, 32'hC0, 11);
    start_run();
    wait_n(15);
    chk("pp2_done", done, 1);
    chk("pp_beats_drained", exp_beats.size(), 0);
    chk("pp_wr_drained", exp_wr.size(), 0);

    // Async reset mid-burst
    pingPong = 0; perB = 0;
    exp_beats.push_back({32'd3, 32'hB0});
    exp_beats.push_back({32'd4, 32'hB1});
    start_run();
    tick(4);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", bus.databus_valid_0, 0);
    chk("arst_done", done, 1);
    chk("arst_addr", bus.databus_addr_0, 0);
    chk("arst_beats", exp_beats.size(), 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("arst_release_done", done, 1);
    chk("final_wr_drained", exp_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
